// File: rtl/wbgpio_irq.sv
// wbgpio_irq: Wishbone GPIO controller with input synchroniser, shared-tick
// debouncer, per-pin rise/fall edge detection, sticky W1C interrupt status,
// interrupt enable mask and atomic set/clear output ports.
module wbgpio_irq #(
  parameter int unsigned      NIN         = 16,
  parameter int unsigned      NOUT        = 16,
  parameter logic [NOUT-1:0]  DEFAULT     = '0,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      DBW         = 16
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_wb_cyc,
  input  logic            i_wb_stb,
  input  logic            i_wb_we,
  input  logic [3:0]      i_wb_addr,
  input  logic [31:0]     i_wb_data,
  input  logic [3:0]      i_wb_sel,
  output logic            o_wb_stall,
  output logic            o_wb_ack,
  output logic [31:0]     o_wb_data,
  input  logic [NIN-1:0]  i_gpio,
  output logic [NOUT-1:0] o_gpio,
  output logic            o_int
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  localparam logic [AW-1:0] ADDR_IN      = 4'd0;
  localparam logic [AW-1:0] ADDR_OUT     = 4'd1;
  localparam logic [AW-1:0] ADDR_OUT_SET = 4'd2;
  localparam logic [AW-1:0] ADDR_OUT_CLR = 4'd3;
  localparam logic [AW-1:0] ADDR_IE      = 4'd4;
  localparam logic [AW-1:0] ADDR_RISE    = 4'd5;
  localparam logic [AW-1:0] ADDR_FALL    = 4'd6;
  localparam logic [AW-1:0] ADDR_ISTAT   = 4'd7;
  localparam logic [AW-1:0] ADDR_DBNC    = 4'd8;

  // Bus decode
  logic          acc;
  logic          wr;
  logic          rd;
  logic [DW-1:0] wmask;
  logic [DW-1:0] wbits;
  logic [DW-1:0] rd_mux;

  // Register file
  logic [NIN-1:0] ie_q;
  logic [NIN-1:0] rise_en_q;
  logic [NIN-1:0] fall_en_q;
  logic [NIN-1:0] istat_q;
  logic [DBW-1:0] dbnc_q;

  // Input path
  logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
  logic [NIN-1:0] sync_s;
  logic [NIN-1:0] samp_q;
  logic [NIN-1:0] din_q;
  logic [NIN-1:0] din_dq;
  logic [DBW-1:0] presc_q;
  logic           dbnc_wr;
  logic           tick;
  logic [NIN-1:0] stable;
  logic [NIN-1:0] rise;
  logic [NIN-1:0] fall;
  logic [NIN-1:0] w1c;

  assign o_wb_stall = 1'b0;

  assign acc     = i_wb_cyc & i_wb_stb;
  assign wr      = acc & i_wb_we;
  assign rd      = acc & ~i_wb_we;
  assign wmask   = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
  assign wbits   = i_wb_data & wmask;
  assign dbnc_wr = wr && (i_wb_addr == ADDR_DBNC);
  assign w1c     = (wr && (i_wb_addr == ADDR_ISTAT)) ? NIN'(wbits) : '0;

  assign sync_s  = sync_q[SYNC_STAGES-1];
  assign tick    = (dbnc_q != '0) && (presc_q == dbnc_q) && !dbnc_wr;
  assign stable  = ~(sync_s ^ samp_q);
  assign rise    = din_q & ~din_dq & rise_en_q;
  assign fall    = ~din_q & din_dq & fall_en_q;

  // Read data multiplexer; unimplemented bits and addresses read as zero
  always_comb begin
    rd_mux = '0;
    case (i_wb_addr)
      ADDR_IN:      rd_mux = DW'(din_q);
      ADDR_OUT,
      ADDR_OUT_SET,
      ADDR_OUT_CLR: rd_mux = DW'(o_gpio);
      ADDR_IE:      rd_mux = DW'(ie_q);
      ADDR_RISE:    rd_mux = DW'(rise_en_q);
      ADDR_FALL:    rd_mux = DW'(fall_en_q);
      ADDR_ISTAT:   rd_mux = DW'(istat_q);
      ADDR_DBNC:    rd_mux = DW'(dbnc_q);
      default:      rd_mux = '0;
    endcase
  end

  // Bus response: single-cycle acknowledge with registered read data
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack  <= acc;
      o_wb_data <= rd ? rd_mux : '0;
    end
  end

  // Output register with byte-lane writes plus atomic set and clear ports
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_gpio <= DEFAULT;
    end else if (wr) begin
      case (i_wb_addr)
        ADDR_OUT:     o_gpio <= (o_gpio & ~NOUT'(wmask)) | NOUT'(wbits);
        ADDR_OUT_SET: o_gpio <= o_gpio | NOUT'(wbits);
        ADDR_OUT_CLR: o_gpio <= o_gpio & ~NOUT'(wbits);
        default:      ;
      endcase
    end
  end

  // Control registers: interrupt enable, edge enables, debounce period
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ie_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      dbnc_q    <= '0;
    end else if (wr) begin
      case (i_wb_addr)
        ADDR_IE:   ie_q      <= (ie_q & ~NIN'(wmask)) | NIN'(wbits);
        ADDR_RISE: rise_en_q <= (rise_en_q & ~NIN'(wmask)) | NIN'(wbits);
        ADDR_FALL: fall_en_q <= (fall_en_q & ~NIN'(wmask)) | NIN'(wbits);
        ADDR_DBNC: dbnc_q    <= (dbnc_q & ~DBW'(wmask)) | DBW'(wbits);
        default:   ;
      endcase
    end
  end

  // Metastability synchroniser for the asynchronous pins
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_gpio};
    end
  end

  // Debounce prescaler and tick sample; a DEBOUNCE write restarts the period
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_q <= '0;
      samp_q  <= '0;
    end else if (dbnc_wr) begin
      presc_q <= '0;
      samp_q  <= sync_s;
    end else if (dbnc_q != '0) begin
      if (presc_q == dbnc_q) begin
        presc_q <= '0;
        samp_q  <= sync_s;
      end else begin
        presc_q <= presc_q + DBW'(1);
      end
    end
  end

  // Debounced value: pass-through when disabled, else bits equal on two ticks
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      din_q <= '0;
    end else if (dbnc_q == '0) begin
      din_q <= sync_s;
    end else if (tick) begin
      din_q <= (din_q & ~stable) | (sync_s & stable);
    end
  end

  // Edge detection, sticky status (new events win over clears) and interrupt
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      din_dq  <= '0;
      istat_q <= '0;
      o_int   <= 1'b0;
    end else begin
      din_dq  <= din_q;
      istat_q <= (istat_q & ~w1c) | rise | fall;
      o_int   <= |(istat_q & ie_q);
    end
  end

endmodule
